// File: rtl/execute_unit.sv
// RV32I execute stage: ALU, branch and address generation behind a one-entry
// output register, with an optional one-bit-per-cycle shifter.
module execute_unit #(
    parameter bit SERIAL_SHIFT = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] pc,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic        funct7_5,
    input  logic [4:0]  rd,
    input  logic        rd_valid,
    input  logic [31:0] imm,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic [4:0]  out_rd,
    output logic        rd_we,
    output logic        mem_op,
    output logic        illegal,
    output logic        br_taken,
    output logic [31:0] br_target
);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;
    typedef enum logic [1:0] {SH_LL, SH_RL, SH_RA} shift_t;

    state_t state, state_nx;

    logic signed [31:0] rs1_s, rs2_s, opb_s;
    logic [31:0] opb;
    logic [4:0]  shamt;
    logic        is_reg;
    logic        accept;
    logic        serial_start;

    logic [31:0] result_p0, br_target_p0;
    logic        rd_we_p0, mem_op_p0, illegal_p0, br_taken_p0, shift_p0;
    shift_t      kind_p0;

    logic [31:0] result_p1, br_target_p1;
    logic [4:0]  rd_p1, cnt_p1;
    logic        rd_we_p1, mem_op_p1, illegal_p1, br_taken_p1;
    shift_t      kind_p1;

    function automatic logic [31:0] shift_step(input logic [31:0] v, input shift_t kind);
        case (kind)
            SH_LL:   return {v[30:0], 1'b0};
            SH_RL:   return {1'b0, v[31:1]};
            default: return {v[31], v[31:1]};
        endcase
    endfunction

    assign is_reg = (opcode == OP_REG);
    assign opb    = is_reg ? rs2_data : imm;
    assign shamt  = is_reg ? rs2_data[4:0] : imm[4:0];
    assign rs1_s  = $signed(rs1_data);
    assign rs2_s  = $signed(rs2_data);
    assign opb_s  = $signed(opb);

    // Stage p0: combinational decode and execute of the offered bundle
    always_comb begin
        result_p0    = '0;
        br_target_p0 = '0;
        rd_we_p0     = 1'b0;
        mem_op_p0    = 1'b0;
        illegal_p0   = 1'b0;
        br_taken_p0  = 1'b0;
        shift_p0     = 1'b0;
        kind_p0      = SH_LL;
        case (opcode)
            OP_LUI: begin
                result_p0 = imm;
                rd_we_p0  = 1'b1;
            end
            OP_AUIPC: begin
                result_p0 = pc + imm;
                rd_we_p0  = 1'b1;
            end
            OP_JAL: begin
                result_p0    = pc + 32'd4;
                br_target_p0 = pc + imm;
                br_taken_p0  = 1'b1;
                rd_we_p0     = 1'b1;
            end
            OP_JALR: begin
                if (funct3 == 3'b000) begin
                    result_p0    = pc + 32'd4;
                    br_target_p0 = (rs1_data + imm) & ~32'd1;
                    br_taken_p0  = 1'b1;
                    rd_we_p0     = 1'b1;
                end else begin
                    illegal_p0 = 1'b1;
                end
            end
            OP_BRANCH: begin
                br_target_p0 = pc + imm;
                case (funct3)
                    3'b000:  br_taken_p0 = (rs1_data == rs2_data);
                    3'b001:  br_taken_p0 = (rs1_data != rs2_data);
                    3'b100:  br_taken_p0 = (rs1_s < rs2_s);
                    3'b101:  br_taken_p0 = !(rs1_s < rs2_s);
                    3'b110:  br_taken_p0 = (rs1_data < rs2_data);
                    3'b111:  br_taken_p0 = !(rs1_data < rs2_data);
                    default: begin
                        illegal_p0   = 1'b1;
                        br_target_p0 = '0;
                    end
                endcase
            end
            OP_LOAD: begin
                case (funct3)
                    3'b000, 3'b001, 3'b010, 3'b100, 3'b101: begin
                        result_p0 = rs1_data + imm;
                        mem_op_p0 = 1'b1;
                    end
                    default: illegal_p0 = 1'b1;
                endcase
            end
            OP_STORE: begin
                case (funct3)
                    3'b000, 3'b001, 3'b010: begin
                        result_p0 = rs1_data + imm;
                        mem_op_p0 = 1'b1;
                    end
                    default: illegal_p0 = 1'b1;
                endcase
            end
            OP_IMM, OP_REG: begin
                rd_we_p0 = 1'b1;
                case (funct3)
                    3'b000:  result_p0 = (is_reg && funct7_5) ? rs1_data - opb : rs1_data + opb;
                    3'b001: begin
                        shift_p0  = 1'b1;
                        kind_p0   = SH_LL;
                        result_p0 = rs1_data << shamt;
                    end
                    3'b010:  result_p0 = {31'd0, rs1_s < opb_s};
                    3'b011:  result_p0 = {31'd0, rs1_data < opb};
                    3'b100:  result_p0 = rs1_data ^ opb;
                    3'b101: begin
                        shift_p0  = 1'b1;
                        kind_p0   = funct7_5 ? SH_RA : SH_RL;
                        result_p0 = funct7_5 ? $unsigned(rs1_s >>> shamt) : rs1_data >> shamt;
                    end
                    3'b110:  result_p0 = rs1_data | opb;
                    default: result_p0 = rs1_data & opb;
                endcase
            end
            default: illegal_p0 = 1'b1;
        endcase
        rd_we_p0 = rd_we_p0 && rd_valid && (rd != 5'd0);
    end

    assign serial_start = SERIAL_SHIFT && shift_p0 && (shamt != 5'd0);
    assign accept       = in_valid && in_ready && !flush;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (flush) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE:    if (accept) state_nx = serial_start ? SHIFT : HOLD;
                SHIFT:   if (cnt_p1 == 5'd1) state_nx = HOLD;
                HOLD:    if (out_ready) state_nx = accept ? (serial_start ? SHIFT : HOLD) : IDLE;
                default: state_nx = IDLE;
            endcase
        end
    end

    always_comb begin
        in_ready  = (state == IDLE) || ((state == HOLD) && out_ready);
        out_valid = (state == HOLD);
        result    = result_p1;
        br_target = br_target_p1;
        out_rd    = rd_p1;
        rd_we     = out_valid && rd_we_p1;
        mem_op    = out_valid && mem_op_p1;
        illegal   = out_valid && illegal_p1;
        br_taken  = out_valid && br_taken_p1;
    end

    // Stage p1: output register, doubling as the serial shift accumulator
    always_ff @(posedge clk) begin
        if (reset) begin
            result_p1    <= '0;
            br_target_p1 <= '0;
            rd_p1        <= '0;
            cnt_p1       <= '0;
            rd_we_p1     <= 1'b0;
            mem_op_p1    <= 1'b0;
            illegal_p1   <= 1'b0;
            br_taken_p1  <= 1'b0;
            kind_p1      <= SH_LL;
        end else if (flush) begin
            cnt_p1 <= '0;
        end else if (accept) begin
            result_p1    <= serial_start ? rs1_data : result_p0;
            cnt_p1       <= serial_start ? shamt : 5'd0;
            br_target_p1 <= br_target_p0;
            rd_p1        <= rd;
            rd_we_p1     <= rd_we_p0;
            mem_op_p1    <= mem_op_p0;
            illegal_p1   <= illegal_p0;
            br_taken_p1  <= br_taken_p0;
            kind_p1      <= kind_p0;
        end else if (state == SHIFT) begin
            result_p1 <= shift_step(result_p1, kind_p1);
            cnt_p1    <= cnt_p1 - 5'd1;
        end
    end

endmodule

// File: tb/tb_execute_unit.sv
// Randomised and directed bench for execute_unit against an arithmetic
// reference model of the RV32I execute rules.
module tb_execute_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] pc = '0;
    logic [6:0]  opcode = '0;
    logic [2:0]  funct3 = '0;
    logic        funct7_5 = 1'b0;
    logic [4:0]  rd = '0;
    logic        rd_valid = 1'b0;
    logic [31:0] imm = '0;
    logic [31:0] rs1_data = '0;
    logic [31:0] rs2_data = '0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result;
    logic [4:0]  out_rd;
    logic        rd_we;
    logic        mem_op;
    logic        illegal;
    logic        br_taken;
    logic [31:0] br_target;

    int vectors = 0;
    int miscompares = 0;

    execute_unit #(.SERIAL_SHIFT(1'b1)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .pc(pc), .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5),
        .rd(rd), .rd_valid(rd_valid), .imm(imm), .rs1_data(rs1_data),
        .rs2_data(rs2_data), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .out_rd(out_rd), .rd_we(rd_we),
        .mem_op(mem_op), .illegal(illegal), .br_taken(br_taken), .br_target(br_target)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic        f7;
        logic [4:0]  rd;
        logic        rdv;
        logic [31:0] imm;
        logic [31:0] rs1;
        logic [31:0] rs2;
    } bundle_t;

    typedef struct packed {
        logic [31:0] result;
        logic [4:0]  rd;
        logic        rd_we;
        logic        mem_op;
        logic        illegal;
        logic        br_taken;
        logic [31:0] br_target;
    } res_t;

    function automatic bundle_t mk(input logic [6:0] opc, input logic [2:0] f3, input logic f7,
                                   input logic [4:0] r, input logic [31:0] im,
                                   input logic [31:0] a, input logic [31:0] b, input logic [31:0] p);
        bundle_t x;
        x.pc = p; x.opc = opc; x.f3 = f3; x.f7 = f7; x.rd = r; x.rdv = 1'b1;
        x.imm = im; x.rs1 = a; x.rs2 = b;
        return x;
    endfunction

    // Reference model: what the architecture says the instruction produces
    function automatic res_t model(input bundle_t b, output int lat);
        res_t e;
        bit legal, writes, is_shift;
        logic [31:0] ob;
        int sh;
        e = '0;
        e.rd = b.rd;
        legal = 1; writes = 0; is_shift = 0;
        ob = (b.opc == 7'h33) ? b.rs2 : b.imm;
        sh = (b.opc == 7'h33) ? int'(b.rs2[4:0]) : int'(b.imm[4:0]);
        case (b.opc)
            7'h37: begin e.result = b.imm; writes = 1; end
            7'h17: begin e.result = b.pc + b.imm; writes = 1; end
            7'h6f: begin e.result = b.pc + 4; e.br_taken = 1; e.br_target = b.pc + b.imm; writes = 1; end
            7'h67: if (b.f3 == 0) begin
                       e.result = b.pc + 4; e.br_taken = 1; writes = 1;
                       e.br_target = b.rs1 + b.imm;
                       e.br_target[0] = 1'b0;
                   end else legal = 0;
            7'h63: begin
                e.br_target = b.pc + b.imm;
                case (b.f3)
                    0: e.br_taken = (b.rs1 == b.rs2);
                    1: e.br_taken = (b.rs1 != b.rs2);
                    4: e.br_taken = ($signed(b.rs1) < $signed(b.rs2));
                    5: e.br_taken = ($signed(b.rs1) >= $signed(b.rs2));
                    6: e.br_taken = (b.rs1 < b.rs2);
                    7: e.br_taken = (b.rs1 >= b.rs2);
                    default: legal = 0;
                endcase
            end
            7'h03: if (b.f3 inside {0, 1, 2, 4, 5}) begin e.result = b.rs1 + b.imm; e.mem_op = 1; end
                   else legal = 0;
            7'h23: if (b.f3 inside {0, 1, 2}) begin e.result = b.rs1 + b.imm; e.mem_op = 1; end
                   else legal = 0;
            7'h13, 7'h33: begin
                writes = 1;
                case (b.f3)
                    0: e.result = (b.opc == 7'h33 && b.f7) ? b.rs1 - ob : b.rs1 + ob;
                    1: begin is_shift = 1; e.result = b.rs1 * (32'd1 << sh); end
                    2: e.result = ($signed(b.rs1) < $signed(ob)) ? 32'd1 : 32'd0;
                    3: e.result = (b.rs1 < ob) ? 32'd1 : 32'd0;
                    4: e.result = b.rs1 ^ ob;
                    5: begin
                        is_shift = 1;
                        if (b.f7 && b.rs1[31]) e.result = ~((~b.rs1) >> sh);
                        else                   e.result = b.rs1 >> sh;
                    end
                    6: e.result = b.rs1 | ob;
                    default: e.result = b.rs1 & ob;
                endcase
            end
            default: legal = 0;
        endcase
        if (!legal) begin
            e = '0; e.rd = b.rd; e.illegal = 1; writes = 0;
        end
        e.rd_we = writes && b.rdv && (b.rd != 0);
        lat = (is_shift && sh != 0) ? sh + 1 : 1;
        return e;
    endfunction

    function automatic res_t sample();
        res_t o;
        o.result = result; o.rd = out_rd; o.rd_we = rd_we; o.mem_op = mem_op;
        o.illegal = illegal; o.br_taken = br_taken; o.br_target = br_target;
        return o;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bundle_t b);
        pc = b.pc; opcode = b.opc; funct3 = b.f3; funct7_5 = b.f7; rd = b.rd;
        rd_valid = b.rdv; imm = b.imm; rs1_data = b.rs1; rs2_data = b.rs2;
    endtask

    // Issue one bundle from IDLE, wait (bounded) for the result, then drain it
    task automatic run_op(input bundle_t b, output res_t o, output int lat);
        drive(b);
        in_valid = 1'b1;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        lat = 1;
        while (out_valid !== 1'b1 && lat < 64) begin
            tick();
            lat++;
        end
        o = sample();
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1; flush = 1'b1; out_ready = 1'b0;
        drive(mk(7'h13, 3'b000, 1'b0, 5'd3, 32'd1, 32'd2, 32'd3, 32'h40));
        in_valid = 1'b1;
        tick(); tick();
        vectors++;
        if ({out_valid, rd_we, br_taken, mem_op, illegal} !== 5'b0) begin
            miscompares++;
            $display("FAIL reset_flags got %b want 00000", {out_valid, rd_we, br_taken, mem_op, illegal});
        end
        vectors++;
        if ({result, br_target, out_rd} !== 69'd0) begin
            miscompares++;
            $display("FAIL reset_data result=%h target=%h rd=%0d want 0", result, br_target, out_rd);
        end
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_in_ready got %b want 1", in_ready);
        end
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        tick();
    endtask

    task automatic test_addi();
        res_t o;
        int lat;
        run_op(mk(7'h13, 3'b000, 1'b0, 5'd5, 32'd7, 32'h15, 32'd0, 32'h100), o, lat);
        vectors++;
        if (lat !== 1 || o.result !== 32'h1C || o.rd_we !== 1'b1 || o.rd !== 5'd5) begin
            miscompares++;
            $display("FAIL addi lat=%0d result=%h we=%b rd=%0d want 1/0000001c/1/5", lat, o.result, o.rd_we, o.rd);
        end
        vectors++;
        if (out_valid !== 1'b0 || rd_we !== 1'b0) begin
            miscompares++;
            $display("FAIL addi_drained valid=%b we=%b want 0/0", out_valid, rd_we);
        end
    endtask

    task automatic test_serial_shift();
        res_t o;
        int lat, busy;
        drive(mk(7'h13, 3'b101, 1'b1, 5'd3, 32'd4, 32'h80000000, 32'd0, 32'h0));
        in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        busy = 0;
        for (int i = 0; i < 4; i++) begin
            if (in_ready === 1'b0 && out_valid === 1'b0) busy++;
            tick();
        end
        vectors++;
        if (busy !== 4) begin
            miscompares++;
            $display("FAIL srai_busy got %0d cycles want 4", busy);
        end
        vectors++;
        if (out_valid !== 1'b1 || result !== 32'hF8000000 || rd_we !== 1'b1) begin
            miscompares++;
            $display("FAIL srai_result valid=%b result=%h we=%b want 1/f8000000/1", out_valid, result, rd_we);
        end
        tick();
        run_op(mk(7'h13, 3'b001, 1'b0, 5'd2, 32'd0, 32'h1234, 32'd0, 32'h0), o, lat);
        vectors++;
        if (lat !== 1 || o.result !== 32'h1234) begin
            miscompares++;
            $display("FAIL slli_zero lat=%0d result=%h want 1/00001234", lat, o.result);
        end
    endtask

    task automatic test_branch();
        res_t o;
        int lat;
        run_op(mk(7'h63, 3'b000, 1'b0, 5'd7, 32'd8, 32'd3, 32'd3, 32'h1C), o, lat);
        vectors++;
        if (o.br_taken !== 1'b1 || o.br_target !== 32'h24 || o.rd_we !== 1'b0) begin
            miscompares++;
            $display("FAIL beq_taken taken=%b target=%h we=%b want 1/00000024/0", o.br_taken, o.br_target, o.rd_we);
        end
        run_op(mk(7'h63, 3'b000, 1'b0, 5'd7, 32'd8, 32'd3, 32'd4, 32'h1C), o, lat);
        vectors++;
        if (o.br_taken !== 1'b0) begin
            miscompares++;
            $display("FAIL beq_not_taken taken=%b want 0", o.br_taken);
        end
        run_op(mk(7'h63, 3'b100, 1'b0, 5'd0, 32'hFFFFFFF0, 32'hFFFFFFFF, 32'd1, 32'h100), o, lat);
        vectors++;
        if (o.br_taken !== 1'b1 || o.br_target !== 32'hF0) begin
            miscompares++;
            $display("FAIL blt_signed taken=%b target=%h want 1/000000f0", o.br_taken, o.br_target);
        end
        run_op(mk(7'h63, 3'b110, 1'b0, 5'd0, 32'd4, 32'hFFFFFFFF, 32'd1, 32'h100), o, lat);
        vectors++;
        if (o.br_taken !== 1'b0) begin
            miscompares++;
            $display("FAIL bltu_unsigned taken=%b want 0", o.br_taken);
        end
    endtask

    task automatic test_jalr();
        res_t o;
        int lat;
        run_op(mk(7'h67, 3'b000, 1'b0, 5'd1, 32'd2, 32'h101, 32'd0, 32'h20), o, lat);
        vectors++;
        if (o.br_target !== 32'h102 || o.result !== 32'h24 || o.rd_we !== 1'b1 || o.br_taken !== 1'b1) begin
            miscompares++;
            $display("FAIL jalr target=%h result=%h we=%b taken=%b want 00000102/00000024/1/1",
                     o.br_target, o.result, o.rd_we, o.br_taken);
        end
        run_op(mk(7'h67, 3'b000, 1'b0, 5'd0, 32'd2, 32'h101, 32'd0, 32'h20), o, lat);
        vectors++;
        if (o.rd_we !== 1'b0 || o.br_target !== 32'h102) begin
            miscompares++;
            $display("FAIL jalr_rd0 we=%b target=%h want 0/00000102", o.rd_we, o.br_target);
        end
    endtask

    task automatic test_illegal();
        res_t o;
        int lat;
        bundle_t cases [4];
        cases[0] = mk(7'h7F, 3'b000, 1'b0, 5'd6, 32'd5, 32'd9, 32'd9, 32'h8);
        cases[1] = mk(7'h63, 3'b010, 1'b0, 5'd6, 32'd5, 32'd9, 32'd9, 32'h8);
        cases[2] = mk(7'h03, 3'b011, 1'b0, 5'd6, 32'd5, 32'd9, 32'd9, 32'h8);
        cases[3] = mk(7'h67, 3'b001, 1'b0, 5'd6, 32'd5, 32'd9, 32'd9, 32'h8);
        foreach (cases[i]) begin
            run_op(cases[i], o, lat);
            vectors++;
            if (lat !== 1 || o.illegal !== 1'b1 || o.result !== 32'd0 || o.rd_we !== 1'b0 || o.br_taken !== 1'b0) begin
                miscompares++;
                $display("FAIL illegal_%0d lat=%0d ill=%b result=%h we=%b taken=%b want 1/1/0/0/0",
                         i, lat, o.illegal, o.result, o.rd_we, o.br_taken);
            end
        end
    endtask

    task automatic test_backpressure();
        int xfers, bad;
        drive(mk(7'h33, 3'b000, 1'b1, 5'd9, 32'd0, 32'd5, 32'd7, 32'h0));
        in_valid = 1'b1; out_ready = 1'b0;
        tick();
        drive(mk(7'h13, 3'b000, 1'b0, 5'd4, 32'd1, 32'd1, 32'd1, 32'h0));
        bad = 0; xfers = 0;
        for (int i = 0; i < 3; i++) begin
            if (out_valid !== 1'b1 || result !== 32'hFFFFFFFE || in_ready !== 1'b0 || out_rd !== 5'd9) bad++;
            tick();
        end
        vectors++;
        if (bad !== 0) begin
            miscompares++;
            $display("FAIL sub_stall %0d unstable cycles want 0 (result=%h)", bad, result);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (out_valid === 1'b1) xfers++;
            tick();
        end
        vectors++;
        if (xfers !== 1) begin
            miscompares++;
            $display("FAIL sub_transfers got %0d want 1", xfers);
        end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        drive(mk(7'h33, 3'b000, 1'b0, 5'd1, 32'd0, 32'd10, 32'd20, 32'h0));
        in_valid = 1'b1;
        tick();
        drive(mk(7'h33, 3'b100, 1'b0, 5'd2, 32'd0, 32'hF0F0, 32'h0FF0, 32'h0));
        vectors++;
        if (out_valid !== 1'b1 || result !== 32'd30 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_first valid=%b result=%h ready=%b want 1/0000001e/1", out_valid, result, in_ready);
        end
        tick();
        drive(mk(7'h13, 3'b001, 1'b0, 5'd3, 32'd3, 32'h11, 32'd0, 32'h0));
        vectors++;
        if (out_valid !== 1'b1 || result !== 32'hFF00 || out_rd !== 5'd2) begin
            miscompares++;
            $display("FAIL b2b_second valid=%b result=%h rd=%0d want 1/0000ff00/2", out_valid, result, out_rd);
        end
        tick();
        in_valid = 1'b0;
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_shift_busy valid=%b ready=%b want 0/0", out_valid, in_ready);
        end
        tick(); tick(); tick();
        vectors++;
        if (out_valid !== 1'b1 || result !== 32'h88) begin
            miscompares++;
            $display("FAIL b2b_shift valid=%b result=%h want 1/00000088", out_valid, result);
        end
        tick();
    endtask

    task automatic test_abort();
        int seen;
        for (int mode = 0; mode < 2; mode++) begin
            drive(mk(7'h33, 3'b001, 1'b0, 5'd4, 32'd0, 32'h3, 32'd10, 32'h0));
            in_valid = 1'b1; out_ready = 1'b1;
            tick();
            in_valid = 1'b0;
            tick(); tick();
            if (mode == 0) reset = 1'b1;
            else           flush = 1'b1;
            in_valid = 1'b1;
            tick();
            reset = 1'b0; flush = 1'b0; in_valid = 1'b0;
            vectors++;
            if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL abort_%0d ready=%b valid=%b want 1/0", mode, in_ready, out_valid);
            end
            seen = 0;
            repeat (16) begin
                if (out_valid === 1'b1) seen++;
                tick();
            end
            vectors++;
            if (seen !== 0) begin
                miscompares++;
                $display("FAIL abort_%0d_ghost %0d out_valid cycles want 0", mode, seen);
            end
        end
        drive(mk(7'h13, 3'b000, 1'b0, 5'd5, 32'd1, 32'd1, 32'd0, 32'h0));
        in_valid = 1'b1; flush = 1'b1;
        tick();
        in_valid = 1'b0; flush = 1'b0;
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_beats_accept valid=%b want 0", out_valid);
        end
        in_valid = 1'b1; out_ready = 1'b0;
        tick();
        in_valid = 1'b0; flush = 1'b1;
        tick();
        flush = 1'b0; out_ready = 1'b1;
        vectors++;
        if (out_valid !== 1'b0 || rd_we !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_hold valid=%b we=%b want 0/0", out_valid, rd_we);
        end
    endtask

    task automatic test_random();
        logic [6:0] opcs [10];
        bundle_t b;
        res_t o, e;
        int lat, elat;
        logic [31:0] r;
        opcs = '{7'h37, 7'h17, 7'h6f, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h00};
        for (int n = 0; n < 300; n++) begin
            r = $urandom;
            b.opc = opcs[$urandom_range(0, 9)];
            if (b.opc == 7'h00) b.opc = 7'($urandom);
            b.f3 = 3'($urandom);
            b.f7 = 1'($urandom);
            b.rd = 5'($urandom);
            b.rdv = ($urandom_range(0, 7) != 0);
            b.imm = (b.opc inside {7'h37, 7'h17}) ? {r[31:12], 12'd0} : {{20{r[11]}}, r[11:0]};
            b.rs1 = $urandom;
            b.rs2 = ($urandom_range(0, 3) == 0) ? b.rs1 : $urandom;
            b.pc = {$urandom, 2'b00} ;
            e = model(b, elat);
            run_op(b, o, lat);
            vectors++;
            if (o !== e || lat !== elat) begin
                miscompares++;
                $display("FAIL random_%0d opc=%h f3=%0d got %h lat %0d want %h lat %0d",
                         n, b.opc, b.f3, o, lat, e, elat);
            end
        end
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_addi();
        test_serial_shift();
        test_branch();
        test_jalr();
        test_illegal();
        test_backpressure();
        test_back_to_back();
        test_abort();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/execute_unit.md
EXECUTE_UNIT -- requirements
Module: execute_unit

Interface
REQ-001 SERIAL_SHIFT, 1, when 1 shifts run one bit per cycle; when 0 shifts complete in a single cycle like every other op.
REQ-002 clk  in  1  single clock; all state changes on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 in_valid  in  1  decoded instruction bundle present.
REQ-005 in_ready  out  1  unit can accept a bundle this cycle.
REQ-006 pc  in  32  address of the instruction.
REQ-007 opcode  in  7; funct3  in  3; funct7_5  in  1 (instr[30]); rd  in  5; rd_valid  in  1; imm  in  32 (sign-extended by decode).
REQ-008 rs1_data, rs2_data  in  32 each  register operands.
REQ-009 flush  in  1  drop any in-flight or held operation.
REQ-010 out_valid  out  1; out_ready  in  1  output handshake.
REQ-011 result  out  32; out_rd  out  5; rd_we  out  1; mem_op  out  1; illegal  out  1.
REQ-012 br_taken  out  1; br_target  out  32  redirect for the program counter.

Function
REQ-013 Transfer in: in_valid && in_ready at a rising edge; transfer out: out_valid && out_ready.
REQ-014 FSM states IDLE, SHIFT, HOLD; in_ready = (IDLE) || (HOLD && out_ready); in SHIFT in_ready = 0.
REQ-015 IDLE/HOLD + accept, non-serial op -> HOLD, out_valid = 1 next cycle (latency 1).
REQ-016 Accept of SLL/SRL/SRA/SLLI/SRLI/SRAI with SERIAL_SHIFT=1 and shamt N>0 -> SHIFT with 5-bit counter = N; one bit shifted per cycle; counter reaches 0 -> HOLD; out_valid asserted N+1 cycles after accept; shamt 0 -> latency 1.
REQ-017 shamt = rs2_data[4:0] (R-type) or imm[4:0] (I-type); SRA/SRAI replicate bit 31.
REQ-018 HOLD && out_ready && !in_valid -> IDLE; with accept -> new op (back-to-back, no bubble).
REQ-019 HOLD && !out_ready: all outputs held stable and bundle inputs ignored.
REQ-020 ALU ops per RV32I: ADD/SUB (funct7_5 selects SUB, R-type only), SLT/SLTU, XOR, OR, AND and immediate forms; arithmetic modulo 2^32, no overflow flag.
REQ-021 LUI: result = imm; AUIPC: result = pc + imm.
REQ-022 JAL: result = pc + 4, br_taken = 1, br_target = pc + imm; JALR: br_target = (rs1_data + imm) & ~1.
REQ-023 Branches BEQ/BNE/BLT/BGE/BLTU/BGEU: br_target = pc + imm, br_taken per signed/unsigned compare, rd_we = 0.
REQ-024 LOAD/STORE: result = rs1_data + imm, mem_op = 1, rd_we = 0.
REQ-025 rd_we = rd_valid && (rd != 0) && op writes rd; out_rd = rd captured at accept.
REQ-026 Unrecognised opcode or funct3: illegal = 1, result = 0, rd_we = 0, br_taken = 0; still completes with latency 1.
REQ-027 br_taken, rd_we, mem_op, illegal are meaningful only while out_valid = 1 and are 0 otherwise.
REQ-028 flush: next state IDLE, out_valid = 0, bundle on in_valid that cycle not accepted; flush has priority over accept and out_ready.

Reset
REQ-029 reset overrides flush and all inputs; next cycle state = IDLE, counter = 0.
REQ-030 Post-reset outputs: out_valid, rd_we, br_taken, mem_op, illegal = 0; result, br_target = 0; out_rd = 0; in_ready = 1.
REQ-031 Reset mid-SHIFT or in HOLD discards the operation; no out_valid for it ever appears.

Verification
REQ-032 ADDI rs1_data=0x15, imm=7, rd=5, out_ready=1 -> one cycle later out_valid=1, result=0x1C, rd_we=1, out_rd=5.
REQ-033 SRAI rs1_data=0x80000000, imm=4, SERIAL_SHIFT=1 -> in_ready=0 for 4 cycles, out_valid 5 cycles after accept, result=0xF8000000.
REQ-034 BEQ pc=0x1C, rs1=rs2=3, imm=8 -> br_taken=1, br_target=0x24, rd_we=0; same with rs2=4 -> br_taken=0.
REQ-035 JALR pc=0x20, rs1_data=0x101, imm=2, rd=1 -> br_target=0x102, result=0x24; rd=0 -> rd_we=0.
REQ-036 SUB 5-7 with out_ready low 3 cycles -> result=0xFFFFFFFE held stable, in_ready=0, single transfer when out_ready rises.
REQ-037 reset (or flush) asserted 2 cycles into SLL with shamt=10 -> IDLE next cycle, out_valid never asserted, in_ready=1.
